// File: rtl/key_note_pkg.sv
// rtl/key_note_pkg.sv - shared types, defaults and base note table for the key note encoder
package key_note_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } note_state_t;

    localparam int DEF_NUM_KEYS        = 9;
    localparam int DEF_FREQ_W          = 9;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    localparam int BASE_ENTRIES = 9;

    // Element 0 is the rightmost entry; the last key has no tone.
    localparam logic [BASE_ENTRIES-1:0][15:0] BASE_FREQ = {
        16'd0, 16'd440, 16'd392, 16'd349, 16'd330,
        16'd294, 16'd262, 16'd247, 16'd220
    };

    function automatic logic [15:0] base_freq(input logic [4:0] idx);
        if (idx < 5'(BASE_ENTRIES)) begin
            return BASE_FREQ[idx[3:0]];
        end
        return 16'd0;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser plus candidate/counter debounce
module key_debounce #(
    parameter int WIDTH           = 9,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] candidate;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            candidate <= '0;
            count     <= '0;
            stable    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Acceptance also requires the input to still match, so a vector
            // that changes on the final count is never taken.
            if (sync2 != candidate) begin
                candidate <= sync2;
                count     <= '0;
            end else if (count != CNT_LAST) begin
                count <= count + CNT_W'(1);
            end else begin
                stable <= candidate;
            end
        end
    end

endmodule

// File: rtl/key_note_encoder.sv
// rtl/key_note_encoder.sv - debounced key vector to note index, frequency and strobe
module key_note_encoder
    import key_note_pkg::*;
#(
    parameter int NUM_KEYS        = DEF_NUM_KEYS,
    parameter int FREQ_W          = DEF_FREQ_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_KEYS-1:0]         keys,
    input  logic [1:0]                  octave,
    output logic [FREQ_W-1:0]           key_freq,
    output logic [$clog2(NUM_KEYS)-1:0] key_idx,
    output logic                        note_on,
    output logic                        note_strobe,
    output logic                        multi_key
);
    localparam int          IDX_W    = $clog2(NUM_KEYS);
    localparam logic [31:0] FREQ_MAX = (FREQ_W >= 32) ? 32'hffff_ffff
                                                      : ((32'd1 << FREQ_W) - 32'd1);

    logic [NUM_KEYS-1:0] db;
    logic [IDX_W-1:0]    idx_c;
    logic                multi_c;
    logic [31:0]         shifted;
    logic [31:0]         sat;
    logic [FREQ_W-1:0]   freq_c;

    note_state_t         state_q;
    note_state_t         state_d;
    logic [FREQ_W-1:0]   freq_d;
    logic [IDX_W-1:0]    idx_d;
    logic                on_d;
    logic                multi_d;
    logic                strobe_d;

    key_debounce #(
        .WIDTH          (NUM_KEYS),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .raw   (keys),
        .stable(db)
    );

    // Scanning downwards leaves the lowest set index as the winner.
    always_comb begin
        idx_c = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (db[i]) begin
                idx_c = IDX_W'(i);
            end
        end
    end

    assign multi_c = |(db & (db - NUM_KEYS'(1)));
    assign shifted = 32'(base_freq(5'(idx_c))) << octave;
    assign sat     = (shifted > FREQ_MAX) ? FREQ_MAX : shifted;
    assign freq_c  = FREQ_W'(sat);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            key_freq    <= '0;
            key_idx     <= '0;
            note_on     <= 1'b0;
            multi_key   <= 1'b0;
            note_strobe <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_freq    <= freq_d;
            key_idx     <= idx_d;
            note_on     <= on_d;
            multi_key   <= multi_d;
            note_strobe <= strobe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|db)  state_d = HELD;
            HELD:    if (~|db) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Octave only feeds freq_d, so an octave change never raises the strobe.
    always_comb begin
        freq_d   = '0;
        idx_d    = '0;
        on_d     = 1'b0;
        multi_d  = 1'b0;
        if (state_d == HELD) begin
            freq_d  = freq_c;
            idx_d   = idx_c;
            on_d    = 1'b1;
            multi_d = multi_c;
        end
        strobe_d = (state_d != state_q) || ((state_d == HELD) && (idx_c != key_idx));
    end

endmodule

// File: tb/tb_key_note_encoder.sv
// tb/tb_key_note_encoder.sv - scoreboard bench for key_note_encoder with directed key vectors
module tb_key_note_encoder;

    localparam int DC  = 4;
    localparam int LAT = DC + 4;

    typedef struct {
        string      name;
        int         cyc;
        logic [8:0] freq;
        logic [3:0] idx;
        logic       on;
        logic       multi;
        logic       strobe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] keys = '0;
    logic [1:0] octave = '0;
    logic [8:0] key_freq;
    logic [3:0] key_idx;
    logic       note_on;
    logic       note_strobe;
    logic       multi_key;

    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    exp_t sb[$];

    key_note_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .keys       (keys),
        .octave     (octave),
        .key_freq   (key_freq),
        .key_idx    (key_idx),
        .note_on    (note_on),
        .note_strobe(note_strobe),
        .multi_key  (multi_key)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t mon_e;
    logic strobe_claimed;

    always @(negedge clk) begin
        strobe_claimed = 1'b0;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            total++;
            if (mon_e.strobe && note_strobe) strobe_claimed = 1'b1;
            if (mon_e.cyc == cyc && key_freq == mon_e.freq && key_idx == mon_e.idx &&
                note_on == mon_e.on && multi_key == mon_e.multi && note_strobe == mon_e.strobe) begin
                passed++;
            end else begin
                $display("FAIL %s cyc=%0d(want %0d) got freq=%0d idx=%0d on=%0b multi=%0b strobe=%0b want freq=%0d idx=%0d on=%0b multi=%0b strobe=%0b",
                         mon_e.name, cyc, mon_e.cyc, key_freq, key_idx, note_on, multi_key, note_strobe,
                         mon_e.freq, mon_e.idx, mon_e.on, mon_e.multi, mon_e.strobe);
            end
        end
        if (note_strobe) begin
            total++;
            if (strobe_claimed) passed++;
            else $display("FAIL unexpected_strobe cyc=%0d got strobe=1 want strobe=0 (freq=%0d idx=%0d)",
                          cyc, key_freq, key_idx);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input string name, input int c, input int f, input int i,
                             input logic on, input logic m, input logic s);
        exp_t e;
        e.name   = name;
        e.cyc    = c;
        e.freq   = 9'(f);
        e.idx    = 4'(i);
        e.on     = on;
        e.multi  = m;
        e.strobe = s;
        sb.push_back(e);
    endtask

    task automatic press(input string name, input logic [8:0] k, input int f, input int i,
                         input logic on, input logic m);
        int c;
        c = cyc;
        keys = k;
        expect_at(name, c + LAT, f, i, on, m, 1'b1);
        expect_at({name, "_hold"}, c + LAT + 1, f, i, on, m, 1'b0);
        step(LAT + 3);
    endtask

    initial begin
        int c;
        step(2);
        expect_at("reset_state", cyc, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step(2);

        expect_at("k1_early", cyc + LAT - 1, 0, 0, 0, 0, 0);
        press("k1_on", 9'b000000001, 220, 0, 1, 0);
        press("k1_off", 9'b000000000, 0, 0, 0, 0);

        c = cyc;
        keys = 9'b000100000;
        expect_at("bounce_quiet", c + LAT, 0, 0, 0, 0, 0);
        expect_at("bounce_quiet2", c + LAT + 3, 0, 0, 0, 0, 0);
        step(3);
        keys = 9'b000000000;
        step(LAT + 4);
        press("k6_on", 9'b000100000, 349, 5, 1, 0);

        press("multi", 9'b010000100, 262, 2, 1, 1);
        press("multi_off", 9'b000000000, 0, 0, 0, 0);

        keys = 9'b000000010;
        step(2);
        press("restart", 9'b000001000, 294, 3, 1, 0);

        press("k3_on", 9'b000000100, 262, 2, 1, 0);
        c = cyc;
        octave = 2'd1;
        expect_at("oct_before", c, 262, 2, 1, 0, 0);
        expect_at("oct_sat", c + 1, 511, 2, 1, 0, 0);
        step(3);
        press("k1_oct1", 9'b000000001, 440, 0, 1, 0);
        c = cyc;
        octave = 2'd0;
        expect_at("oct_back", c + 1, 220, 0, 1, 0, 0);
        step(3);

        press("k8_on", 9'b010000000, 440, 7, 1, 0);
        c = cyc;
        reset = 1'b1;
        expect_at("rst_clear", c, 0, 0, 0, 0, 0);
        step(1);
        reset = 1'b0;
        c = cyc;
        expect_at("rst_quiet", c + LAT - 1, 0, 0, 0, 0, 0);
        expect_at("rst_again", c + LAT, 440, 7, 1, 0, 1);
        step(LAT + 3);

        press("k9_on", 9'b100000000, 0, 8, 1, 0);
        press("k9_off", 9'b000000000, 0, 0, 0, 0);

        for (int k = 0; k < 100 && sb.size() > 0; k++) step(1);
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
